pixel_rr_arbiter: RTL
=====================

# pixel_rr_arbiter

- Shares one downstream WIDTH-bit pixel channel between four upstream pixel sources (e.g. parallel filter lanes feeding a common write-back path).
- Grants round-robin over valid/ready handshakes, steers the winning source through a 4:1 select and registers the word into a one-entry output stage.
- Optionally holds the grant for a whole burst.

## Interface

Parameters:
- WIDTH, 10, pixel word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  4  per-source word valid, bit i = source i.
- req_last  in  4  per-source end-of-burst flag; used only with burst lock.
- req_data0..req_data3  in  WIDTH each  source words.
- req_ready  out  4  per-source accept, one-hot or zero.
- out_valid  out  1  output word valid.
- out_data  out  WIDTH  output word.
- out_src  out  2  index of the source that produced out_data.
- out_ready  in  1  downstream accept.
- sel  out  2  current combinational grant index, driving the 4:1 select.

## Operation

- load_en = !out_valid | out_ready.
- Priority pointer ptr (2 bits): the search starts at ptr, then ptr+1, ptr+2, ptr+3, all mod 4.
- grant is the first index in that order with req_valid set.
- sel = grant. When no source is valid, sel holds its last registered grant.
- req_ready[i] = load_en & req_valid[i] & (grant == i). At most one bit is set. Handshakes are combinational from req_valid/out_ready; there is no registered ready.
- Transfer on source i (req_valid[i] & req_ready[i]):
  - out_data <= req_data[i].
  - out_src <= i.
  - out_valid <= 1.
- If load_en and no transfer occurs, out_valid <= 0.
- If !load_en, out_valid, out_data and out_src hold.
- ptr update on each transfer in state ARB: ptr <= grant + 1, with 2-bit wrap (3 -> 0).
- FSM states (2-state; see Configuration):
  - ARB: free arbitration.
  - LOCK: grant forced to owner (registered index); other sources see req_ready = 0.
  - ARB -> LOCK: on a transfer with req_last[grant] = 0.
  - LOCK -> ARB: on an owner transfer with req_last = 1. ptr <= owner + 1 on this transition; ptr does not change inside LOCK.
  - Owner dropping req_valid while in LOCK: stay in LOCK and issue no grants. No timeout.
- Boundaries:
  - No valid sources: no transfer, ptr unchanged.
  - All four valid continuously with out_ready = 1: service order 0, 1, 2, 3, 0, ...
  - out_ready = 0 while out_valid = 1: req_ready = 0 and the output is stable.
  - Reset during a burst or stall: the word in flight is discarded and the block returns to its reset state.

## Timing

- Reset values:
  - out_valid 0, out_data 0, out_src 0.
  - ptr 0, owner 0, state ARB.
  - sel 0, req_ready 0.
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one word per cycle while out_ready = 1. The simultaneous drain and load in the same cycle (out_valid & out_ready & a transfer) is supported with no bubble.
- Fairness: with all four sources valid, each source waits at most 3 transfers between grants. In LOCK, the wait additionally includes the current burst length.

## Configuration

- Macro: PIXEL_ARB_BURST_LOCK_EN.
- Defined: LOCK state, owner register and req_last are active as described.
- Undefined: the FSM stays in ARB permanently, every transfer advances ptr, req_last is ignored, and the owner register is removed.

## Structure

- The shared package holds:
  - arbiter state typedef (ARB, LOCK);
  - NUM_SRC = 4 and SRC_W = 2 constants;
  - the reset values for ptr and out_src.
- Sub-module: rr_pick4, a purely combinational rotating priority picker.
  - Inputs: req_valid[3:0], ptr[1:0].
  - Outputs: grant[1:0], any_valid.
- The 4:1 data select and the output register stay in the top module.

## Test plan

- Reset: assert rst mid-stream with out_valid = 1 -> out_valid, out_data, out_src and sel read 0 immediately; the first post-reset grant goes to source 0.
- Full contention: all sources valid, req_dataN = 0x100+N, out_ready = 1 -> out_data sequence 0x100, 0x101, 0x102, 0x103, 0x100, out_src 0, 1, 2, 3, 0, one word per cycle.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> req_ready = 0000, and out_data/out_src hold; on release, the next word arrives one cycle later with no loss or duplication.
- Sparse: only source 2 valid, then only source 1 -> grants 2 then 1; ptr = 3 after the first transfer and 2 after the second.
- Burst lock (macro defined): source 1 sends 4 words with req_last on the 4th while sources 0 and 3 are valid -> four consecutive out_src = 1, then source 3 is granted. A mid-burst req_valid gap on source 1 produces no grant to others.
- Macro undefined: same stimulus as the burst-lock scenario -> out_src sequence 1, 3, 0, 1, ...; req_last has no effect.

Source files
------------

// File: rtl/pixel_rr_arbiter_pkg.sv
// Shared types and constants for the four-source round-robin pixel arbiter.
// Optional burst lock is enabled with the PIXEL_ARB_BURST_LOCK_EN macro.
package pixel_rr_arbiter_pkg;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned SRC_W   = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam logic [SRC_W-1:0] PTR_RST     = '0;
  localparam logic [SRC_W-1:0] OUT_SRC_RST = '0;

  // Next source index with natural 2-bit wrap (3 -> 0).
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    return idx + SRC_W'(1);
  endfunction

endpackage

// File: rtl/pixel_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first valid source at or after ptr.
module rr_pick4
  import pixel_rr_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_valid,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   grant,
  output logic               any_valid
);

  logic [SRC_W-1:0] idx;

  // Walk from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    grant     = ptr;
    idx       = '0;
    any_valid = |req_valid;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = ptr + SRC_W'(k);
      if (req_valid[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/pixel_rr_arbiter.sv
// Four-source round-robin arbiter feeding a one-entry registered pixel output stage.
// Define PIXEL_ARB_BURST_LOCK_EN to hold the grant until the owner flags req_last.
module pixel_rr_arbiter
  import pixel_rr_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  req_valid,
  input  logic [NUM_SRC-1:0]  req_last,
  input  logic [WIDTH-1:0]    req_data0,
  input  logic [WIDTH-1:0]    req_data1,
  input  logic [WIDTH-1:0]    req_data2,
  input  logic [WIDTH-1:0]    req_data3,
  output logic [NUM_SRC-1:0]  req_ready,
  output logic                out_valid,
  output logic [WIDTH-1:0]    out_data,
  output logic [SRC_W-1:0]    out_src,
  input  logic                out_ready,
  output logic [SRC_W-1:0]    sel
);

  arb_state_t       state_q, state_d;
  logic [SRC_W-1:0] ptr_q, ptr_d;
  logic [SRC_W-1:0] sel_q;
  logic [SRC_W-1:0] pick_grant;
  logic             any_valid;
  logic [SRC_W-1:0] grant;
  logic             grant_valid;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] data_mux;

`ifdef PIXEL_ARB_BURST_LOCK_EN
  logic [SRC_W-1:0] owner_q, owner_d;
`else
  logic             unused_last;
  assign unused_last = ^req_last;
`endif

  rr_pick4 u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_grant),
    .any_valid (any_valid)
  );

  // Grant resolution, handshake and select; nothing is accepted while reset is held.
  always_comb begin
`ifdef PIXEL_ARB_BURST_LOCK_EN
    grant = (state_q == LOCK) ? owner_q : pick_grant;
`else
    grant = pick_grant;
`endif
    grant_valid = req_valid[grant];
    load_en     = !out_valid || out_ready;
    xfer        = !rst && load_en && grant_valid;
    req_ready   = xfer ? (NUM_SRC'(1) << grant) : '0;
    sel         = (any_valid || (state_q == LOCK)) ? grant : sel_q;
  end

  always_comb begin
    case (grant)
      2'd0:    data_mux = req_data0;
      2'd1:    data_mux = req_data1;
      2'd2:    data_mux = req_data2;
      default: data_mux = req_data3;
    endcase
  end

  // Next-state: pointer moves past the winner in ARB, past the owner on burst end.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
`ifdef PIXEL_ARB_BURST_LOCK_EN
    owner_d = owner_q;
    case (state_q)
      ARB: begin
        if (xfer) begin
          ptr_d = next_idx(grant);
          if (!req_last[grant]) begin
            state_d = LOCK;
            owner_d = grant;
          end
        end
      end
      LOCK: begin
        if (xfer && req_last[owner_q]) begin
          state_d = ARB;
          ptr_d   = next_idx(owner_q);
        end
      end
      default: state_d = ARB;
    endcase
`else
    state_d = ARB;
    if (xfer) ptr_d = next_idx(grant);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= PTR_RST;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel;
    end
  end

`ifdef PIXEL_ARB_BURST_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) owner_q <= '0;
    else     owner_q <= owner_d;
  end
`endif

  // One-entry output stage; drains and reloads in the same cycle when out_ready is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= OUT_SRC_RST;
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= data_mux;
        out_src  <= grant;
      end
    end
  end

endmodule
